cache_ram_param_valid: RTL and testbench

- Parametrised successor of the 16-entry, 512-bit byte-enable cache RAM.
- Adds a per-entry valid bit, a read request/valid handshake with hit flag, and optional write-to-read forwarding.
- Adds a sequenced flush: an automatic sweep after reset, and an on-demand sweep.
- Sits under the L1 instruction/data cache controllers as their data + valid store; the controllers perform tag compare externally.

---
 rtl/cache_ram_pkg.sv | 33 +++
 rtl/cache_ram_flush_ctrl.sv | 65 ++++++
 rtl/cache_ram_param_valid.sv | 124 ++++++++++++
 tb/tb_cache_ram_param_valid.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ram_pkg.sv
// Shared definitions for the parametrised cache RAM.
//   flush_state_e       : flush sequencer state encoding.
//   func_byteena_merge  : per-byte merge of a write line into the current line.
//     Callers size-cast lines up to MergeMaxW bits and truncate the result back
//     to DATA_W.
package cache_ram_pkg;

  typedef enum logic {
    L_PARAM_IDLE  = 1'b0,
    L_PARAM_SWEEP = 1'b1
  } flush_state_e;

  // Widest line the merge helper handles; DATA_W must not exceed this.
  localparam int unsigned MergeMaxW = 4096;
  localparam int unsigned MergeBeW  = MergeMaxW / 8;

  // Enabled bytes come from wr, all other bytes are kept from cur.
  function automatic logic [MergeMaxW-1:0] func_byteena_merge(
    input logic [MergeBeW-1:0]  byteena,
    input logic [MergeMaxW-1:0] cur,
    input logic [MergeMaxW-1:0] wr
  );
    logic [MergeMaxW-1:0] res;
    res = cur;
    for (int k = 0; k < int'(MergeBeW); k++) begin
      if (byteena[k]) begin
        res[8*k +: 8] = wr[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_ram_flush_ctrl.sv
// Flush sequencer: sweeps every entry's valid bit to zero, once after reset
// and again on each flush request accepted while idle.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset; (re)starts a sweep at entry 0
//   flush_req_i : one-cycle flush request, ignored while sweeping
//   busy_o      : sweep in progress (high for exactly 2**ADDR_W cycles)
//   clr_en_o    : clear valid bit at clr_addr_o this cycle
//   clr_addr_o  : entry being cleared
module cache_ram_flush_ctrl
  import cache_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_req_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  flush_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      L_PARAM_IDLE: begin
        if (flush_req_i) begin
          state_d = L_PARAM_SWEEP;
          cnt_d   = '0;
        end
      end
      L_PARAM_SWEEP: begin
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = L_PARAM_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = L_PARAM_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= L_PARAM_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // state_q is itself a register, so busy is registered.
  assign busy_o     = (state_q == L_PARAM_SWEEP);
  assign clr_en_o   = (state_q == L_PARAM_SWEEP);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/cache_ram_param_valid.sv
// Parametrised byte-enable cache data RAM with per-entry valid bits.
//   iCLOCK / iRESET_SYNC           : clock, synchronous active-high reset
//   iFLUSH_REQ / oFLUSH_BUSY       : invalidate-all request / sweep in progress
//   iWR_EN/ADDR/BYTEENA/DATA       : byte-masked line write, sets valid
//   iINV_EN/ADDR                   : clear one valid bit (wins over a write)
//   iRD_EN/ADDR                    : read request, 1-cycle latency
//   oRD_VALID/HIT/DATA             : read result pulse, valid bit, line
// All requests are dropped while the flush sweep is running.
module cache_ram_param_valid
  import cache_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 512,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH_REQ,
  output logic                oFLUSH_BUSY,
  input  logic                iWR_EN,
  input  logic [ADDR_W-1:0]   iWR_ADDR,
  input  logic [DATA_W/8-1:0] iWR_BYTEENA,
  input  logic [DATA_W-1:0]   iWR_DATA,
  input  logic                iINV_EN,
  input  logic [ADDR_W-1:0]   iINV_ADDR,
  input  logic                iRD_EN,
  input  logic [ADDR_W-1:0]   iRD_ADDR,
  output logic                oRD_VALID,
  output logic                oRD_HIT,
  output logic [DATA_W-1:0]   oRD_DATA
);

  localparam int unsigned ENTRY_N = 2 ** ADDR_W;

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  cache_ram_flush_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_flush_ctrl (
    .clk_i       (iCLOCK),
    .reset_i     (iRESET_SYNC),
    .flush_req_i (iFLUSH_REQ),
    .busy_o      (busy),
    .clr_en_o    (clr_en),
    .clr_addr_o  (clr_addr)
  );

  assign oFLUSH_BUSY = busy;

  logic wr_acc, inv_acc, rd_acc;
  assign wr_acc  = iWR_EN  & ~busy & ~iRESET_SYNC;
  assign inv_acc = iINV_EN & ~busy & ~iRESET_SYNC;
  assign rd_acc  = iRD_EN  & ~busy & ~iRESET_SYNC;

  logic [DATA_W-1:0]  mem_q [ENTRY_N];
  logic [ENTRY_N-1:0] valid_q;

  // Merged write line; also the forwarded read line when addresses match.
  logic [DATA_W-1:0] wr_line;
  assign wr_line = DATA_W'(func_byteena_merge(MergeBeW'(iWR_BYTEENA),
                                              MergeMaxW'(mem_q[iWR_ADDR]),
                                              MergeMaxW'(iWR_DATA)));

  logic              rd_fwd, rd_inv;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_hit_d;

  assign rd_fwd = (BYPASS == 1'b1) && wr_acc && (iWR_ADDR == iRD_ADDR);
  assign rd_inv = inv_acc && (iINV_ADDR == iRD_ADDR);

  always_comb begin
    rd_data_d = mem_q[iRD_ADDR];
    rd_hit_d  = valid_q[iRD_ADDR];
    if (rd_fwd) begin
      rd_data_d = wr_line;
      rd_hit_d  = ~rd_inv;
    end
  end

  // Data array is intentionally not reset.
  always_ff @(posedge iCLOCK) begin
    if (wr_acc) begin
      mem_q[iWR_ADDR] <= wr_line;
    end
  end

  // Valid bits are cleared by the sweep rather than by reset.
  always_ff @(posedge iCLOCK) begin
    if (clr_en) begin
      valid_q[clr_addr] <= 1'b0;
    end else begin
      if (wr_acc) begin
        valid_q[iWR_ADDR] <= 1'b1;
      end
      if (inv_acc) begin
        valid_q[iINV_ADDR] <= 1'b0;
      end
    end
  end

  logic              rd_valid_q, rd_hit_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_hit_q  <= rd_hit_d;
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign oRD_VALID = rd_valid_q;
  assign oRD_HIT   = rd_hit_q;
  assign oRD_DATA  = rd_data_q;

endmodule

// File: tb/tb_cache_ram_param_valid.sv
module tb_cache_ram_param_valid;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_req;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [63:0]  wr_be;
  logic [511:0] wr_data;
  logic         inv_en;
  logic [3:0]   inv_addr;
  logic         rd_en;
  logic [3:0]   rd_addr;

  logic         busy1, rdv1, hit1;
  logic [511:0] data1;
  logic         busy0, rdv0, hit0;
  logic [511:0] data0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_ram_param_valid #(.ADDR_W(4), .DATA_W(512), .BYPASS(1'b1)) u_dut_byp (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .iFLUSH_REQ  (flush_req),
    .oFLUSH_BUSY (busy1),
    .iWR_EN      (wr_en),
    .iWR_ADDR    (wr_addr),
    .iWR_BYTEENA (wr_be),
    .iWR_DATA    (wr_data),
    .iINV_EN     (inv_en),
    .iINV_ADDR   (inv_addr),
    .iRD_EN      (rd_en),
    .iRD_ADDR    (rd_addr),
    .oRD_VALID   (rdv1),
    .oRD_HIT     (hit1),
    .oRD_DATA    (data1)
  );

  cache_ram_param_valid #(.ADDR_W(4), .DATA_W(512), .BYPASS(1'b0)) u_dut_nob (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .iFLUSH_REQ  (flush_req),
    .oFLUSH_BUSY (busy0),
    .iWR_EN      (wr_en),
    .iWR_ADDR    (wr_addr),
    .iWR_BYTEENA (wr_be),
    .iWR_DATA    (wr_data),
    .iINV_EN     (inv_en),
    .iINV_ADDR   (inv_addr),
    .iRD_EN      (rd_en),
    .iRD_ADDR    (rd_addr),
    .oRD_VALID   (rdv0),
    .oRD_HIT     (hit0),
    .oRD_DATA    (data0)
  );

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0;
    wr_en     = 1'b0;
    inv_en    = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    wr_addr = '0; wr_be = '0; wr_data = '0; inv_addr = '0; rd_addr = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy1); end
    total++; if (rdv1 !== 1'b0 || hit1 !== 1'b0) begin bad++;
      $display("FAIL reset_rd: got v=%b h=%b want 0 0", rdv1, hit1); end
    total++; if (data1 !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", data1); end
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin n++; step(); end
    total++; if (n != 16) begin bad++; $display("FAIL reset_sweep_len: got %0d want 16", n); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy_nob: got %b want 0", busy0); end
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_en = 1'b0;
    total++; if (rdv1 !== 1'b1 || hit1 !== 1'b0) begin bad++;
      $display("FAIL first_read: got v=%b h=%b want 1 0", rdv1, hit1); end
    total++; if (rdv0 !== 1'b1 || hit0 !== 1'b0) begin bad++;
      $display("FAIL first_read_nob: got v=%b h=%b want 1 0", rdv0, hit0); end
    step();
    total++; if (rdv1 !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse: got %b want 0", rdv1); end
  endtask

  task automatic test_byteena();
    logic [511:0] exp;
    exp = fill(8'hAA);
    exp[7:0] = 8'h55;
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = '1; wr_data = fill(8'hAA);
    step();
    wr_be = 64'h1; wr_data = fill(8'h55);
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    total++; if (data1 !== exp || hit1 !== 1'b1) begin bad++;
      $display("FAIL byteena: got h=%b %0h want h=1 %0h", hit1, data1, exp); end
    total++; if (data0 !== exp || hit0 !== 1'b1) begin bad++;
      $display("FAIL byteena_nob: got h=%b %0h want h=1 %0h", hit0, data0, exp); end
    step();
    total++; if (rdv1 !== 1'b0 || data1 !== exp) begin bad++;
      $display("FAIL rd_hold: got v=%b %0h want v=0 %0h", rdv1, data1, exp); end
  endtask

  task automatic test_bypass();
    logic [511:0] exp;
    exp = '0;
    exp[127:64] = {8{8'h3C}};
    wr_en = 1'b1; wr_addr = 4'd7; wr_be = '1; wr_data = '0;
    step();
    wr_en = 1'b0; inv_en = 1'b1; inv_addr = 4'd7;
    step();
    inv_en = 1'b0;
    wr_en = 1'b1; wr_be = 64'hFF00; wr_data = fill(8'h3C);
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    wr_en = 1'b0;
    total++; if (data1 !== exp || hit1 !== 1'b1) begin bad++;
      $display("FAIL bypass_on: got h=%b %0h want h=1 %0h", hit1, data1, exp); end
    total++; if (data0 !== '0 || hit0 !== 1'b0) begin bad++;
      $display("FAIL bypass_off: got h=%b %0h want h=0 0", hit0, data0); end
    step();
    rd_en = 1'b0;
    total++; if (data0 !== exp || hit0 !== 1'b1) begin bad++;
      $display("FAIL bypass_after: got h=%b %0h want h=1 %0h", hit0, data0, exp); end
  endtask

  task automatic test_wr_inv();
    logic [511:0] pat;
    for (int k = 0; k < 64; k++) pat[8*k +: 8] = 8'(k);
    // write + invalidate + read all on entry 2 in one cycle
    wr_en = 1'b1; wr_addr = 4'd2; wr_be = '1; wr_data = pat;
    inv_en = 1'b1; inv_addr = 4'd2;
    rd_en = 1'b1; rd_addr = 4'd2;
    step();
    wr_en = 1'b0; inv_en = 1'b0;
    total++; if (data1 !== pat || hit1 !== 1'b0) begin bad++;
      $display("FAIL wr_inv_fwd: got h=%b %0h want h=0 %0h", hit1, data1, pat); end
    total++; if (hit0 !== 1'b0) begin bad++; $display("FAIL wr_inv_old: got %b want 0", hit0); end
    step();
    rd_en = 1'b0;
    total++; if (data0 !== pat || hit0 !== 1'b0 || data1 !== pat || hit1 !== 1'b0) begin bad++;
      $display("FAIL wr_inv_read: got h=%b/%b want h=0 data %0h", hit1, hit0, pat); end
    // read + invalidate on entry 9: pre-invalidate valid is returned
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = fill(8'h99);
    step();
    wr_en = 1'b0; inv_en = 1'b1; inv_addr = 4'd9; rd_en = 1'b1; rd_addr = 4'd9;
    step();
    inv_en = 1'b0;
    total++; if (hit1 !== 1'b1 || hit0 !== 1'b1) begin bad++;
      $display("FAIL rd_inv_same: got %b/%b want 1/1", hit1, hit0); end
    step();
    rd_en = 1'b0;
    total++; if (hit1 !== 1'b0 || hit0 !== 1'b0 || data1 !== fill(8'h99)) begin bad++;
      $display("FAIL rd_after_inv: got h=%b/%b %0h want 0/0 %0h", hit1, hit0, data1, fill(8'h99)); end
  endtask

  task automatic test_flush();
    int n;
    logic [511:0] exp;
    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_be = '1; wr_data = fill(8'(8'h10 + a));
      step();
    end
    wr_en = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      n++;
      flush_req = (n == 5);
      wr_en = 1'b1; wr_addr = 4'd0; wr_be = '1; wr_data = fill(8'hFF);
      step();
    end
    idle_inputs();
    total++; if (n != 16) begin bad++; $display("FAIL flush_len: got %0d want 16", n); end
    for (int a = 0; a < 16; a++) begin
      exp = fill(8'(8'h10 + a));
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      total++; if (rdv1 !== 1'b1 || hit1 !== 1'b0 || data1 !== exp) begin bad++;
        $display("FAIL flush_read[%0d]: got v=%b h=%b %0h want v=1 h=0 %0h", a, rdv1, hit1, data1, exp); end
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    idle_inputs();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 10) begin n++; step(); end
    total++; if (n != 10) begin bad++; $display("FAIL pre_reset_busy: got %0d want 10", n); end
    rst = 1'b1; rd_en = 1'b1; rd_addr = 4'd1;
    step();
    rst = 1'b0; rd_en = 1'b0;
    total++; if (rdv1 !== 1'b0 || data1 !== '0 || rdv0 !== 1'b0 || data0 !== '0) begin bad++;
      $display("FAIL mid_reset_rd: got v=%b %0h want v=0 0", rdv1, data1); end
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin n++; step(); end
    total++; if (n != 16) begin bad++; $display("FAIL mid_reset_len: got %0d want 16", n); end
  endtask

  initial begin
    test_reset();
    test_byteena();
    test_bypass();
    test_wr_inv();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
